dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the CPU load/store stage: accepts r_v/w_v requests with
//  address, write data and byte strobe; performs word-organised SRAM reads/writes.
//  Returns load data on the 16-bit mem_res bus with a one-cycle hit pulse after a fixed latency.
//  Sits between the mem stage and the data memory; it is the single responder on that interface.
// PARAMETERS
//  XLEN          32    request address/data width
//  DEPTH_WORDS   1024  backing store size in XLEN-bit words (power of two)
//  READ_LATENCY  2     cycles from read acceptance to hit (>=1)
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     asynchronous active-low reset
//  r_v         in   1     read request valid
//  w_v         in   1     write request valid
//  req_adr     in   XLEN  byte address
//  req_data    in   XLEN  write data, lanes aligned to strobe
//  req_strobe  in   4     byte-lane enables (0001/0010/0100/1000, 0011/0110/1100, 1111)
//  hit         out  1     load data valid, one-cycle pulse
//  mem_res     out  16    load data
//  busy        out  1     read in flight; new requests are not accepted
//  err         out  1     sticky: out-of-range access or r_v&w_v seen; cleared by reset only
// BEHAVIOUR
//  - Reset (async, rst_n=0): hit=0, mem_res=0, busy=0, err=0, state IDLE, latency counter 0.
//    SRAM contents not reset. Reset mid-read aborts it: no hit is issued after release.
//  - Word index = req_adr[2 +: log2(DEPTH_WORDS)]. Address bits above that range nonzero
//    means out of range: write dropped; read returns mem_res=0 with a normal hit; err set.
//  - States: IDLE -> WAIT (read accepted) -> RESP -> IDLE.
//    IDLE: r_v&!w_v: latch index and strobe, load counter with READ_LATENCY-1, go WAIT, busy=1.
//          w_v&!r_v: write strobed lanes on this edge, stay IDLE, no hit, busy stays 0.
//          r_v&w_v: request ignored, err set.
//    WAIT: decrement counter. At 0, go RESP and latch mem_res.
//          With READ_LATENCY=1, WAIT is left on its first cycle.
//    RESP: hit=1 for exactly one cycle, busy=0 in that cycle, return to IDLE.
//          hit rises READ_LATENCY+1 edges after the accepting edge.
//  - Requests arriving while busy=1 are ignored: no write, no state change.
//    The requester holds them until busy=0.
//  - Lane extraction from latched word W and strobe S:
//    single byte lane k -> {{8{W[8k+7]}}, W[8k+:8]}; halfword 0011 -> W[15:0];
//    0110 -> W[23:8]; 1100 -> W[31:16]; 1111 -> W[15:0].
//    The requester performs final 32-bit sign or zero extension from bit 15.
//  - Writes update only bytes whose strobe bit is 1, taking req_data from the same lane.
//  - mem_res holds its last value between hits. hit never asserts without a preceding read.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined:
//    Strobe is checked against req_adr[1:0]: single byte lane k requires adr[1:0]=k;
//    0011/0110/1100 require adr[1:0]=0/1/2; 1111 requires 0. Any other strobe is illegal.
//    On a misaligned or illegal request: write dropped; read completes with mem_res=0; err set.
//  DMEM_MISALIGN_TRAP_EN undefined: no check; strobe alone selects lanes; adr[1:0] ignored.
// TESTING
//  1 Write adr=0x10 data=0xDEADBEEF strobe=1111, then read adr=0x10 strobe=1111
//    -> hit exactly 3 edges after the read edge (LAT=2), mem_res=0xBEEF.
//  2 After test 1, read adr=0x13 strobe=1000 -> mem_res=0xFFDE; adr=0x11 strobe=0110 -> 0xADBE.
//  3 Write adr=0x10 data=0x00AA0000 strobe=0100, then read strobe=0100 -> mem_res=0xFFAA.
//    Read again with strobe=1111 -> mem_res=0xBEEF (lane 1 untouched).
//  4 Read accepted, w_v pulsed while busy=1, and rst_n dropped during WAIT
//    -> write has no effect, no hit after reset release, outputs return to reset values.
//  5 r_v=w_v=1 -> no state change, err=1. Read adr=0x1000 (DEPTH 1024)
//    -> hit with mem_res=0, err=1.
//  6 DMEM_MISALIGN_TRAP_EN defined, write adr=0x13 strobe=0011 -> memory unchanged, err=1.
//    Undefined: lanes 0-1 written.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised SRAM behind the mem stage.
// Accepts strobed reads/writes and returns 16-bit load data with a hit pulse.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   r_v, w_v          read / write request valid
//   req_adr           byte address (XLEN)
//   req_data          write data, lanes aligned to req_strobe
//   req_strobe        byte-lane enables
//   hit               one-cycle load-data-valid pulse
//   mem_res           16-bit load data, held between hits
//   busy              read in flight, requests ignored
//   err               sticky error (out of range, r_v&w_v, misaligned)
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> strobe checked against req_adr[1:0]; bad requests trap
//   undefined -> strobe alone selects lanes, req_adr[1:0] ignored
module dmem_responder #(
  parameter int XLEN         = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [XLEN-1:0] req_adr,
  input  logic [XLEN-1:0] req_data,
  input  logic [3:0]      req_strobe,
  output logic            hit,
  output logic [15:0]     mem_res,
  output logic            busy,
  output logic            err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW =
    (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_LOAD =
    CW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Backing store, not reset (SRAM semantics)
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_strb;
  logic            r_bad;
  logic            r_hit;
  logic [15:0]     r_mem_res;
  logic            r_busy;
  logic            r_err;

  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_hi;
  logic            w_oor;
  logic            w_mis;
  logic            w_bad;
  logic            w_idle;
  logic            w_rd_acc;
  logic            w_wr_acc;
  logic            w_both;
  logic            w_we;

  // Lane extraction; single bytes are sign-extended
  // to 16 bits, the requester finishes to 32 bits.
  function automatic logic [15:0] f_lane(
    input logic [31:0] w,
    input logic [3:0]  s
  );
    logic [15:0] v;
    case (s)
      4'b0001: v = {{8{w[7]}},  w[7:0]};
      4'b0010: v = {{8{w[15]}}, w[15:8]};
      4'b0100: v = {{8{w[23]}}, w[23:16]};
      4'b1000: v = {{8{w[31]}}, w[31:24]};
      4'b0011: v = w[15:0];
      4'b0110: v = w[23:8];
      4'b1100: v = w[31:16];
      4'b1111: v = w[15:0];
      default: v = w[15:0];
    endcase
    return v;
  endfunction

  assign w_idx = req_adr[2 +: AW];

  // Any address bit above the word index
  // means the access is outside the store.
  assign w_hi  = req_adr >> (2 + AW);
  assign w_oor = |w_hi;

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic f_misaligned(
    input logic [3:0] s,
    input logic [1:0] a
  );
    logic m;
    case (s)
      4'b0001: m = (a != 2'd0);
      4'b0010: m = (a != 2'd1);
      4'b0100: m = (a != 2'd2);
      4'b1000: m = (a != 2'd3);
      4'b0011: m = (a != 2'd0);
      4'b0110: m = (a != 2'd1);
      4'b1100: m = (a != 2'd2);
      4'b1111: m = (a != 2'd0);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  assign w_mis = f_misaligned(req_strobe, req_adr[1:0]);
`else
  logic w_unused_adr_lo;
  assign w_unused_adr_lo = ^req_adr[1:0];
  assign w_mis = 1'b0;
`endif

  assign w_bad    = w_oor | w_mis;
  assign w_idle   = (r_state == S_IDLE);
  assign w_both   = w_idle & r_v & w_v;
  assign w_rd_acc = w_idle & r_v & ~w_v;
  assign w_wr_acc = w_idle & w_v & ~r_v;
  assign w_we     = w_wr_acc & ~w_bad;

  // Strobed write port; only enabled lanes change
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (req_strobe[k]) begin
          r_mem[w_idx][8*k +: 8] <= req_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_strb    <= '0;
      r_bad     <= 1'b0;
      r_hit     <= 1'b0;
      r_mem_res <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            w_both: begin
              r_err <= 1'b1;
            end
            w_rd_acc: begin
              r_idx   <= w_idx;
              r_strb  <= req_strobe;
              r_bad   <= w_bad;
              r_cnt   <= LAT_LOAD;
              r_busy  <= 1'b1;
              r_state <= S_WAIT;
              if (w_bad) r_err <= 1'b1;
            end
            w_wr_acc: begin
              if (w_bad) r_err <= 1'b1;
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= S_RESP;
            r_mem_res <= r_bad ? 16'h0000 :
              f_lane(r_mem[r_idx][31:0], r_strb);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          // hit and busy drop land in the same cycle
          r_hit   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hit     = r_hit;
  assign mem_res = r_mem_res;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule
